// File: rtl/nba_write_merge_queue.sv
// Byte-masked write-coalescing FIFO. A write to the same address as the youngest
// queued entry is merged into it byte by byte (last write wins). Other writes
// allocate a new entry. Entries leave in order, each as one masked update.
// Ports:
//   clk, rst_n                       clock, async active-low reset
//   in_valid/in_ready                write request handshake (in_ready = !full, registered)
//   in_addr/in_data/in_strb          write address, data, byte enables
//   out_valid/out_ready              head entry handshake
//   out_addr/out_data/out_strb       head entry contents (strb=0 lanes read as 0)
//   count                            occupied entries
module nba_write_merge_queue #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 4,
  parameter int unsigned DEPTH  = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [ADDR_W-1:0]            in_addr,
  input  logic [DATA_W-1:0]            in_data,
  input  logic [DATA_W/8-1:0]          in_strb,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [ADDR_W-1:0]            out_addr,
  output logic [DATA_W-1:0]            out_data,
  output logic [DATA_W/8-1:0]          out_strb,
  output logic [$clog2(DEPTH):0]       count
);

  localparam int unsigned STRB_W = DATA_W / 8;
  localparam int unsigned PTR_W  = $clog2(DEPTH);
  localparam int unsigned CNT_W  = PTR_W + 1;

  logic [ADDR_W-1:0] r_addr [DEPTH];
  logic [DATA_W-1:0] r_data [DEPTH];
  logic [STRB_W-1:0] r_strb [DEPTH];
  logic [PTR_W-1:0]  r_head;
  logic [PTR_W-1:0]  r_tail;
  logic [CNT_W-1:0]  r_count;
  logic              r_in_ready;
  logic              r_out_valid;

  logic              w_push;
  logic              w_pop;
  logic              w_merge;
  logic              w_alloc;
  logic [PTR_W-1:0]  w_tail_m1;
  logic [DATA_W-1:0] w_tail_data;
  logic [DATA_W-1:0] w_new_data;
  logic [DATA_W-1:0] w_mrg_data;
  logic [CNT_W-1:0]  w_count_nxt;

  assign w_push      = in_valid & r_in_ready;
  assign w_pop       = r_out_valid & out_ready;
  assign w_tail_m1   = r_tail - PTR_W'(1);
  assign w_tail_data = r_data[w_tail_m1];

  // Only the youngest entry merges; a head that is leaving this cycle is left alone.
  assign w_merge = (r_count != '0) && (r_addr[w_tail_m1] == in_addr) &&
                   !((r_count == CNT_W'(1)) && w_pop);
  assign w_alloc = w_push & ~w_merge;

  // Per-lane data for a fresh entry and for a merge into the youngest entry.
  always_comb begin
    w_new_data = '0;
    w_mrg_data = '0;
    for (int b = 0; b < int'(STRB_W); b++) begin
      w_new_data[b*8 +: 8] = in_strb[b] ? in_data[b*8 +: 8] : 8'h00;
      w_mrg_data[b*8 +: 8] = in_strb[b] ? in_data[b*8 +: 8] : w_tail_data[b*8 +: 8];
    end
  end

  // Occupancy changes only when exactly one of allocate/pop happens.
  always_comb begin
    w_count_nxt = r_count;
    if (w_alloc && !w_pop) begin
      w_count_nxt = r_count + CNT_W'(1);
    end else if (!w_alloc && w_pop) begin
      w_count_nxt = r_count - CNT_W'(1);
    end
  end

  // Queue storage, pointers and registered flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        r_addr[i] <= '0;
        r_data[i] <= '0;
        r_strb[i] <= '0;
      end
      r_head      <= '0;
      r_tail      <= '0;
      r_count     <= '0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
    end else begin
      // Pop and allocate never hit the same slot: allocate implies not full,
      // and pop implies not empty.
      if (w_pop) begin
        r_addr[r_head] <= '0;
        r_data[r_head] <= '0;
        r_strb[r_head] <= '0;
        r_head         <= r_head + PTR_W'(1);
      end
      if (w_alloc) begin
        r_addr[r_tail] <= in_addr;
        r_data[r_tail] <= w_new_data;
        r_strb[r_tail] <= in_strb;
        r_tail         <= r_tail + PTR_W'(1);
      end else if (w_push) begin
        r_data[w_tail_m1] <= w_mrg_data;
        r_strb[w_tail_m1] <= r_strb[w_tail_m1] | in_strb;
      end
      r_count     <= w_count_nxt;
      r_in_ready  <= (w_count_nxt != CNT_W'(DEPTH));
      r_out_valid <= (w_count_nxt != '0);
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign out_addr  = r_addr[r_head];
  assign out_data  = r_data[r_head];
  assign out_strb  = r_strb[r_head];
  assign count     = r_count;

endmodule

// File: tb/tb_nba_write_merge_queue.sv
// Directed bench for nba_write_merge_queue with a scoreboard of expected pops.
module tb_nba_write_merge_queue;

  typedef struct packed {
    logic [3:0]  a;
    logic [31:0] d;
    logic [3:0]  s;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [3:0]  in_addr = '0;
  logic [31:0] in_data = '0;
  logic [3:0]  in_strb = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [3:0]  out_addr;
  logic [31:0] out_data;
  logic [3:0]  out_strb;
  logic [2:0]  count;

  int checks = 0;
  int failures = 0;
  exp_t sb[$];

  nba_write_merge_queue #(.DATA_W(32), .ADDR_W(4), .DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_addr(in_addr), .in_data(in_data), .in_strb(in_strb),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_addr(out_addr), .out_data(out_data), .out_strb(out_strb),
    .count(count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every accepted pop must match the oldest expected entry.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL pop_unexpected: got addr %0h data %0h strb %0h expected nothing",
                 out_addr, out_data, out_strb);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("pop_addr", 64'(out_addr), 64'(e.a));
        chk("pop_data", 64'(out_data), 64'(e.d));
        chk("pop_strb", 64'(out_strb), 64'(e.s));
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [3:0] a, input logic [31:0] d, input logic [3:0] s);
    in_valid = 1'b1;
    in_addr  = a;
    in_data  = d;
    in_strb  = s;
    cyc();
  endtask

  task automatic idle();
    in_valid = 1'b0;
  endtask

  task automatic expect_pop(input logic [3:0] a, input logic [31:0] d, input logic [3:0] s);
    exp_t e;
    e.a = a;
    e.d = d;
    e.s = s;
    sb.push_back(e);
  endtask

  task automatic drain(input int n);
    out_ready = 1'b1;
    repeat (n) cyc();
    out_ready = 1'b0;
  endtask

  initial begin
    #12;
    chk("reset_in_ready", 64'(in_ready), 64'd1);
    chk("reset_out_valid", 64'(out_valid), 64'd0);
    chk("reset_count", 64'(count), 64'd0);
    chk("reset_out_data", 64'(out_data), 64'd0);
    rst_n = 1'b1;
    cyc();

    // Whole then partial, same address.
    expect_pop(4'd3, 32'hFFFFFF00, 4'hF);
    push(4'd3, 32'hFFFFFFFF, 4'hF);
    chk("t1_latency_valid", 64'(out_valid), 64'd1);
    push(4'd3, 32'h00000000, 4'h1);
    idle();
    chk("t1_count_merged", 64'(count), 64'd1);
    drain(1);
    chk("t1_count_empty", 64'(count), 64'd0);

    // Partial then whole.
    expect_pop(4'd5, 32'h12345678, 4'hF);
    push(4'd5, 32'h000000AA, 4'h1);
    push(4'd5, 32'h12345678, 4'hF);
    idle();
    chk("t2_count", 64'(count), 64'd1);
    drain(1);

    // Interleaved addresses keep order and do not merge across.
    expect_pop(4'd1, 32'd1, 4'hF);
    expect_pop(4'd2, 32'd2, 4'hF);
    expect_pop(4'd1, 32'd3, 4'hF);
    push(4'd1, 32'd1, 4'hF);
    push(4'd2, 32'd2, 4'hF);
    push(4'd1, 32'd3, 4'hF);
    idle();
    chk("t3_count", 64'(count), 64'd3);
    drain(3);
    chk("t3_count_empty", 64'(count), 64'd0);

    // Zero-strobe merge is a no-op; zero-strobe allocate gives an empty entry.
    expect_pop(4'd4, 32'h00000055, 4'h1);
    expect_pop(4'd6, 32'h00000000, 4'h0);
    push(4'd4, 32'hAAAAAA55, 4'h1);
    push(4'd4, 32'hFFFFFFFF, 4'h0);
    push(4'd6, 32'hFFFFFFFF, 4'h0);
    idle();
    chk("t4_count", 64'(count), 64'd2);
    drain(2);

    // Full, refused push, pop-then-refill across the wrap.
    expect_pop(4'd8,  32'h80, 4'hF);
    expect_pop(4'd9,  32'h90, 4'hF);
    expect_pop(4'd10, 32'hA0, 4'hF);
    expect_pop(4'd11, 32'hB0, 4'hF);
    expect_pop(4'd12, 32'hC0, 4'hF);
    expect_pop(4'd13, 32'hD0, 4'hF);
    push(4'd8,  32'h80, 4'hF);
    push(4'd9,  32'h90, 4'hF);
    push(4'd10, 32'hA0, 4'hF);
    push(4'd11, 32'hB0, 4'hF);
    chk("t5_count_full", 64'(count), 64'd4);
    chk("t5_in_ready_full", 64'(in_ready), 64'd0);
    push(4'd11, 32'hEE, 4'hF);
    idle();
    chk("t5_refused_count", 64'(count), 64'd4);
    drain(2);
    chk("t5_count_half", 64'(count), 64'd2);
    push(4'd12, 32'hC0, 4'hF);
    push(4'd13, 32'hD0, 4'hF);
    idle();
    chk("t5_count_wrap", 64'(count), 64'd4);
    out_ready = 1'b1;
    push(4'd14, 32'hE0, 4'hF);
    idle();
    out_ready = 1'b0;
    chk("t5_pop_while_full_count", 64'(count), 64'd3);
    chk("t5_in_ready_after", 64'(in_ready), 64'd1);
    drain(3);
    chk("t5_count_empty", 64'(count), 64'd0);

    // Head protection: same-address push while the only entry is popped.
    expect_pop(4'd7, 32'h00000011, 4'h1);
    expect_pop(4'd7, 32'h00002200, 4'h2);
    push(4'd7, 32'h00000011, 4'h1);
    idle();
    out_ready = 1'b1;
    push(4'd7, 32'h00002200, 4'h2);
    idle();
    out_ready = 1'b0;
    chk("t6_count", 64'(count), 64'd1);
    chk("t6_new_head_data", 64'(out_data), 64'h00002200);
    drain(1);

    // Reset mid-stream drops everything immediately.
    push(4'd1, 32'h1, 4'hF);
    push(4'd2, 32'h2, 4'hF);
    push(4'd3, 32'h3, 4'hF);
    idle();
    chk("t7_count_before", 64'(count), 64'd3);
    #2 rst_n = 1'b0;
    #1;
    chk("t7_rst_out_valid", 64'(out_valid), 64'd0);
    chk("t7_rst_count", 64'(count), 64'd0);
    chk("t7_rst_in_ready", 64'(in_ready), 64'd1);
    chk("t7_rst_out_data", 64'(out_data), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    cyc();
    expect_pop(4'd3, 32'h00001234, 4'h3);
    push(4'd3, 32'hAABB1234, 4'h3);
    idle();
    chk("t7_fresh_count", 64'(count), 64'd1);
    drain(1);

    cyc();
    cyc();
    chk("sb_empty", 64'(sb.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/nba_write_merge_queue.md
Name: nba_write_merge_queue

Overview:
- Byte-masked write-coalescing FIFO that sits directly upstream of a byte-lane register, or register file, updated by nonblocking assignments.
- Accepts whole-word and partial (byte-strobe) writes and merges back-to-back writes to the same address into one entry.
- Within a merged entry, the last write wins per byte. Across the queue, writes commit in order.
- Downstream applies each popped entry as one masked update, so mixed whole/partial writes to a register resolve deterministically.

Parameters:
- DATA_W, 32, data width in bits; must be a multiple of 8.
- ADDR_W, 4, target register address width.
- DEPTH, 4, queue entries; power of two, at least 2.

Ports:
- clk  in  1  clock; all state updates on its rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  write request valid.
- in_ready  out  1  queue can accept; equals !full, with no combinational path from in_*.
- in_addr  in  ADDR_W  target address.
- in_data  in  DATA_W  write data.
- in_strb  in  DATA_W/8  byte enables; all-ones is a whole-word write.
- out_valid  out  1  head entry valid.
- out_ready  in  1  consumer accepts head.
- out_addr  out  ADDR_W  head address.
- out_data  out  DATA_W  head merged data; bytes with strb=0 are don't-care but driven 0.
- out_strb  out  DATA_W/8  head merged byte enables.
- count  out  $clog2(DEPTH)+1  occupied entries.

Behaviour:
- Reset (async assert, sync-to-clk deassert handled externally):
  - all entries invalid; head = tail = 0; count = 0.
  - in_ready = 1, out_valid = 0, out_addr/out_data/out_strb = 0.
  - Reset mid-operation drops all pending entries; nothing partial is emitted.
- push = in_valid & in_ready.
- pop = out_valid & out_ready.
- Outputs are driven directly from the head entry registers. A pushed write is visible on out_* the cycle after the push edge, so latency is 1. There is no same-cycle bypass.
- Merge-eligible when all of the following hold:
  - count ≥ 1;
  - youngest entry (tail-1) address == in_addr;
  - NOT (count == 1 and pop this cycle). The head being consumed is never modified.
- Merge, per byte lane i:
  - if in_strb[i], entry.data byte i ← in_data byte i and entry.strb[i] ← 1;
  - else the lane is unchanged.
  - count is unchanged by the merge itself; the tail does not move.
- Non-merge push: allocate at tail.
  - data lanes with strb=0 are written 0.
  - tail ← tail+1 mod DEPTH.
- Only the youngest entry merges. An older entry with the same address is never touched, which preserves ordering against intervening other-address writes.
- Pop: head ← head+1 mod DEPTH; the freed entry is cleared to 0.
- count updates:
  - +1 on allocate without pop;
  - −1 on pop without allocate;
  - unchanged otherwise, including merge+pop and allocate+pop.
- Full (count == DEPTH):
  - in_ready = 0, even if the write would merge; no push is accepted.
  - A pop in the same cycle does not raise in_ready until the next cycle.
- Empty: out_valid = 0; out_ready is ignored.
- in_strb == 0 with push:
  - merge-eligible → accepted, no data change;
  - otherwise → allocates an entry with strb 0. The consumer treats it as a no-op.
- Head and tail pointers wrap modulo DEPTH; count distinguishes full from empty.
- out_* are held stable while out_valid & !out_ready, unless a merge targets the head entry while it is not being popped. Consumers sample only on pop.

Test Plan:
- Whole then partial, same address:
  - push (a=3, d=32'hFFFFFFFF, s=4'hF), next cycle push (a=3, d=32'h00000000, s=4'h1), out_ready=0;
  - then raise out_ready → single pop: addr 3, data 32'hFFFFFF00, strb 4'hF; count returns 0.
- Partial then whole:
  - push (a=5, d=32'h000000AA, s=4'h1), then (a=5, d=32'h12345678, s=4'hF) → one entry: data 32'h12345678, strb 4'hF.
- Interleaved addresses:
  - pushes to addr 1, 2, 1 (s=4'hF, d=1, 2, 3) → three pops in order with data 1, 2, 3. The second addr-1 write does not merge.
- Full and wrap:
  - DEPTH=4; push 4 distinct addresses with out_ready=0 → count=4, in_ready=0; a 5th in_valid is not accepted.
  - Then pop 2 and push 2 → correct order across the pointer wrap; count=4.
- Head protection:
  - count=1 (a=7, d=8'h11 in byte 0); same cycle pop and push (a=7, s=4'h2, d=32'h00002200) → popped data 32'h00000011, s=4'h1.
  - New entry: data 32'h00002200, s=4'h2; count stays 1.
- Reset mid-stream:
  - 3 entries queued; assert rst_n=0 asynchronously between edges → immediately out_valid=0, count=0, in_ready=1, out_data=0.
  - After release, the next push behaves as on a fresh queue.
